nibble_add_scan_ctrl: RTL and testbench
=======================================

NIBBLE_ADD_SCAN_CTRL -- requirements
Module: nibble_add_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving clock cycles per display digit slot (legal range 2..2^20).
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports: clk input 1, the single rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a 16-bit add; honoured only in IDLE.
REQ-004 SHALL have ports a and b, input, 16 bits each: operands, sampled on the accepted start edge.
REQ-005 SHALL have port cin, input, 1 bit: carry-in, sampled with a and b.
REQ-006 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.
REQ-008 SHALL have ports sum (output, 16 bits) and cout (output, 1 bit): last completed result.
REQ-009 SHALL have port seg, output, 7 bits: active-low segments; seg[0]=a through seg[6]=g.
REQ-010 SHALL have port an, output, 4 bits: active-low digit enables, one-hot-low.

Function
REQ-011 SHALL implement FSM states IDLE, ADD and DONE.
REQ-012 In IDLE, start=1 at an edge SHALL latch a, b and cin, clear the nibble index to 0, and enter ADD.
REQ-013 In ADD, each edge SHALL add operand nibbles [4i+3:4i] plus the carry register through one 4-bit carry-lookahead adder; this write SHALL store the 4-bit result into working-sum nibble i and the adder carry-out into the carry register.
REQ-014 The carry register SHALL be loaded with cin on start acceptance.
REQ-015 After the edge that processes nibble 3, the FSM SHALL enter DONE; that same edge SHALL copy the working sum to sum and the final carry to cout atomically.
REQ-016 Latency: with start accepted at edge 0, nibbles 0..3 are processed at edges 1..4 and done is high for exactly the cycle after edge 4.
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally; start asserted in DONE is ignored.
REQ-018 start asserted during ADD or DONE SHALL be ignored, with no effect on operands, result or timing; no start queuing occurs.
REQ-019 Holding start high continuously SHALL restart the add on each IDLE cycle, giving one result per 6 cycles.
REQ-020 sum and cout SHALL hold their values between completions.
REQ-021 The scan counter SHALL count 0..SCAN_DIV-1 continuously, independent of the FSM; on wrap, the digit index 0..3 SHALL increment modulo 4.
REQ-022 an SHALL drive low only bit [digit index]; seg SHALL show the hex glyph (0-F, standard a-g) of sum nibble [digit index].
REQ-023 seg and an SHALL be registered, updating one cycle after the digit index or sum changes.

Reset
REQ-024 rst SHALL asynchronously force: state IDLE, busy=0, done=0, sum=0, cout=0, operand/carry/working registers 0, scan counter 0, digit index 0, an=4'b1110, seg=7'b1000000 (glyph "0").
REQ-025 rst asserted mid-ADD SHALL abort the operation; no partial result reaches sum and done does not pulse.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, NIBBLES=4, and the 16-entry active-low hex-to-segment constant table.
REQ-027 One sub-module, cla4_nibble, SHALL provide the combinational 4-bit carry-lookahead adder (inputs a[3:0], b[3:0], ci; outputs s[3:0], co), instantiated exactly once.

Verification
REQ-028 Test a=0x1234, b=0x4321, cin=0, start at edge 0 -> busy high edges 0..5, done high only in the cycle after edge 4, sum=0x5555, cout=0.
REQ-029 Test 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1; then 0x0000+0x0000, cin=1 -> sum=0x0001, cout=0.
REQ-030 Test 0x8000+0x8000 with start re-pulsed during ADD carrying operands 0x1111/0x1111 -> single done, sum=0x0000, cout=1; re-pulse ignored.
REQ-031 Test rst asserted at edge 2 of an add of 0xABCD+0x1111 -> immediate IDLE, sum=0x0000, no done pulse, an=4'b1110.
REQ-032 Test SCAN_DIV=4 with sum=0x5A5A -> an cycles 1110,1101,1011,0111,1110 every 4 cycles; seg alternates 7'b0010010 ("5") and 7'b0001000 ("A").

Source files
------------

// File: rtl/nibble_add_scan_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder with a multiplexed
// 4-digit seven-segment display.
package nibble_add_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NIBBLES = 4;

  // Active-low glyphs for 0-F, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/nibble_add_scan_ctrl_cla4.sv
// Combinational 4-bit carry-lookahead adder: one nibble slice of the
// serial 16-bit add.
module cla4_nibble
  import nibble_add_scan_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Carries are expanded from generate/propagate rather than rippled
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];

endmodule

// File: rtl/nibble_add_scan_ctrl.sv
// 16-bit adder processed one nibble per clock through a single CLA slice,
// with the last result shown on a scanned 4-digit seven-segment display.
module nibble_add_scan_ctrl
  import nibble_add_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e      r_state;
  state_e      w_next;

  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_work;
  logic [15:0] r_sum;
  logic        r_c;
  logic        r_cout;
  logic [1:0]  r_idx;

  logic [3:0]  w_na;
  logic [3:0]  w_nb;
  logic [3:0]  w_s;
  logic        w_co;
  logic        w_last;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]  r_dig;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic [3:0]  w_dig_nib;

  assign w_na   = r_a[{r_idx, 2'b00} +: 4];
  assign w_nb   = r_b[{r_idx, 2'b00} +: 4];
  assign w_last = (r_idx == 2'(NIBBLES - 1));

  cla4_nibble u_cla (
    .a  (w_na),
    .b  (w_nb),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADD;
      S_ADD:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are only captured in IDLE, so start pulses while busy are inert
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_idx  <= '0;
      r_work <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_idx <= '0;
          end
        end
        S_ADD: begin
          r_work[{r_idx, 2'b00} +: 4] <= w_s;
          r_c   <= w_co;
          r_idx <= r_idx + 2'd1;
          // Top nibble is still in flight, so it is merged straight in
          if (w_last) begin
            r_sum  <= {w_s, r_work[11:0]};
            r_cout <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dig <= '0;
    end else if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
      r_cnt <= '0;
      r_dig <= r_dig + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_dig_nib = r_sum[{r_dig, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1110;
      r_seg <= 7'b1000000;
    end else begin
      r_an  <= ~(4'b0001 << r_dig);
      r_seg <= SEG_LUT[w_dig_nib];
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule

// File: tb/tb_nibble_add_scan_ctrl.sv
// Scoreboard bench: stimulus pushes expected {cout,sum}; a negedge monitor
// pops and compares on every done pulse.
module tb_nibble_add_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  logic [16:0] exp_q[$];

  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_A = 7'b0001000;

  nibble_add_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      logic [16:0] e;
      n_done++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e[15:0]));
        chk("sb_cout", 32'(cout), 32'(e[16]));
      end
    end
  end

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_add(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic [15:0] es, input logic ec);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    exp_q.push_back({ec, es});
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(12);
  endtask

  initial begin
    int d0;
    int idx;
    bit found;
    logic [3:0] prev_an;
    logic [3:0] an_seq [4];
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    rst = 1'b0;

    // 0x1234 + 0x4321: cycle-by-cycle busy/done timing
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 16'h5555});
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("t1_busy_e%0d", k), 32'(busy), 32'(k <= 4));
      chk($sformatf("t1_done_e%0d", k), 32'(done), 32'(k == 4));
      if (k == 3) chk("t1_sum_hold", 32'(sum), 32'h0000);
      if (k == 4) chk("t1_sum", 32'(sum), 32'h5555);
    end

    // Full carry ripple and carry-in only
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_add(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    do_add(16'h0F0F, 16'h0F0F, 1'b1, 16'h1E1F, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_sum_hold", 32'(sum), 32'h1E1F);

    // Start re-pulse during ADD with different operands is ignored
    d0 = n_done;
    @(negedge clk);
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b1, 16'h0000});
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; a = 16'h1111; b = 16'h1111;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(12);
    repeat (8) @(negedge clk);
    chk("t3_done_count", 32'(n_done - d0), 32'd1);
    chk("t3_sum", 32'(sum), 32'h0000);
    chk("t3_cout", 32'(cout), 32'd1);

    // Held start: one result every 6 cycles
    d0 = n_done;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
    repeat (3) exp_q.push_back({1'b0, 16'h1010});
    repeat (18) @(posedge clk);
    #1 start = 1'b0;
    wait_idle(12);
    chk("t4_done_count", 32'(n_done - d0), 32'd3);
    chk("t4_period", 32'(last_done_cyc - prev_done_cyc), 32'd6);

    // Reset mid-ADD aborts with no result
    d0 = n_done;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_sum", 32'(sum), 32'h0000);
    chk("t5_an", 32'(an), 32'(4'b1110));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_no_done", 32'(n_done - d0), 32'd0);
    chk("t5_sum_after", 32'(sum), 32'h0000);

    // Display scan of 0x5A5A
    do_add(16'h5A5A, 16'h0000, 1'b0, 16'h5A5A, 1'b0);
    prev_an = an;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (an !== prev_an) found = 1'b1;
    end
    chk("t6_scan_moves", 32'(found), 32'd1);
    idx = 0;
    for (int j = 0; j < 4; j++) if (an === an_seq[j]) idx = j;
    chk("t6_an_first", 32'(an), 32'(an_seq[idx]));
    chk("t6_seg_first", 32'(seg), 32'(idx[0] ? SEG_5 : SEG_A));
    for (int r = 0; r < 5; r++) begin
      repeat (2) @(negedge clk);
      chk($sformatf("t6_an_mid%0d", r), 32'(an), 32'(an_seq[idx]));
      repeat (2) @(negedge clk);
      idx = (idx + 1) % 4;
      chk($sformatf("t6_an%0d", r), 32'(an), 32'(an_seq[idx]));
      chk($sformatf("t6_seg%0d", r), 32'(seg), 32'(idx[0] ? SEG_5 : SEG_A));
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
